// File: rtl/pong_pkg.sv
// Shared Pong controller definitions: state encoding, game modes, synchronizer default.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_SERVE  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_HIT_LD = 3'd4,
        ST_PT_LD  = 3'd5,
        ST_CHECK  = 3'd6,
        ST_OVER   = 3'd7
    } state_t;

    localparam logic MODE_1P = 1'b0;
    localparam logic MODE_2P = 1'b1;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pong_ctrl_2p_tick_sync.sv
// Brings the divided game clock into the Clk domain; tick_o is a one-cycle pulse per rising edge.
module tick_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic tick_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign tick_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pong_ctrl_2p.sv
// Pong game sequencer: drives datapath strobes, holding Clk_out-domain strobes until a game-clock tick.
// Build option PONG_CTRL_SERVE_DELAY_EN: serve waits on the 5 s timer instead of lasting one cycle.
module pong_ctrl_2p
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       mode,
    input  logic       hit,
    input  logic       miss_l,
    input  logic       miss_r,
    input  logic       T5_out,
    input  logic       winner,
    input  logic       Clk_out,
    output logic       mode_o,
    output logic       T5_en,
    output logic       T5_rst,
    output logic       T20_en,
    output logic       T20_rst,
    output logic       Lvl_clr,
    output logic       Hit_ld,
    output logic       Hit_clr,
    output logic       P1_ld,
    output logic       P1_clr,
    output logic       P2_ld,
    output logic       P2_clr,
    output logic       ball_rst,
    output logic       ball_run,
    output logic [2:0] state_o
);

`ifdef PONG_CTRL_SERVE_DELAY_EN
    localparam logic SERVE_DELAY = 1'b1;
`else
    localparam logic SERVE_DELAY = 1'b0;
`endif

    state_t state_q, state_d;
    logic   mode_d;
    logic   credit_p1_q, credit_p1_d;
    logic   miss_pend_q, miss_pend_d;
    logic   tick;
    logic   any_miss;
    logic   entry;

    tick_sync #(.STAGES(SYNC_STAGES)) u_tick_sync (
        .clk_i   (Clk),
        .rst_n_i (Rst),
        .async_i (Clk_out),
        .tick_o  (tick)
    );

    assign any_miss = miss_l | miss_r;
    assign entry    = (state_d != state_q);
    assign state_o  = state_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_o;
        credit_p1_d = credit_p1_q;
        miss_pend_d = miss_pend_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    mode_d  = mode;
                    state_d = ST_CLR;
                end
            end
            ST_CLR:   if (tick) state_d = ST_SERVE;
            ST_SERVE: if (!SERVE_DELAY || T5_out) state_d = ST_PLAY;
            ST_PLAY: begin
                // A miss always outranks a simultaneous hit.
                if (mode_o == MODE_1P) begin
                    if (any_miss) begin
                        state_d = ST_OVER;
                    end else if (hit) begin
                        state_d     = ST_HIT_LD;
                        miss_pend_d = 1'b0;
                    end
                end else if (miss_l && miss_r) begin
                    state_d = ST_SERVE;
                end else if (any_miss) begin
                    credit_p1_d = miss_r;
                    state_d     = ST_PT_LD;
                end
            end
            ST_HIT_LD: begin
                if (any_miss) miss_pend_d = 1'b1;
                if (tick) begin
                    state_d     = (miss_pend_q || any_miss) ? ST_OVER : ST_PLAY;
                    miss_pend_d = 1'b0;
                end
            end
            ST_PT_LD: if (tick) state_d = ST_CHECK;
            ST_CHECK: state_d = winner ? ST_OVER : ST_SERVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe is registered alongside it.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            credit_p1_q <= 1'b0;
            miss_pend_q <= 1'b0;
            mode_o      <= MODE_1P;
            T5_en       <= 1'b0;
            T5_rst      <= 1'b0;
            T20_en      <= 1'b0;
            T20_rst     <= 1'b0;
            Lvl_clr     <= 1'b0;
            Hit_ld      <= 1'b0;
            Hit_clr     <= 1'b0;
            P1_ld       <= 1'b0;
            P1_clr      <= 1'b0;
            P2_ld       <= 1'b0;
            P2_clr      <= 1'b0;
            ball_rst    <= 1'b1;
            ball_run    <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_p1_q <= credit_p1_d;
            miss_pend_q <= miss_pend_d;
            mode_o      <= mode_d;
            T5_rst      <= SERVE_DELAY && (state_d == ST_SERVE) && entry;
            T5_en       <= SERVE_DELAY && (state_d == ST_SERVE) && !entry;
            T20_en      <= (state_d == ST_PLAY) && (mode_d == MODE_1P);
            T20_rst     <= (state_d == ST_CLR) && entry;
            Lvl_clr     <= (state_d == ST_CLR) && entry;
            Hit_clr     <= (state_d == ST_CLR);
            P1_clr      <= (state_d == ST_CLR);
            P2_clr      <= (state_d == ST_CLR);
            Hit_ld      <= (state_d == ST_HIT_LD);
            P1_ld       <= (state_d == ST_PT_LD) && credit_p1_d;
            P2_ld       <= (state_d == ST_PT_LD) && !credit_p1_d;
            ball_rst    <= (state_d == ST_IDLE) || (state_d == ST_SERVE);
            ball_run    <= (state_d == ST_PLAY) || (state_d == ST_HIT_LD);
        end
    end

endmodule
